rr_mux_reg: RTL and testbench

- Parametrised N:1 datapath selector with round-robin arbitration and a registered output stage.
- Successor to the fixed 8:1 32-bit combinational selector used in the ALU datapath.
- Adds per-channel valid/ready handshakes, fair arbitration and output buffering, so multiple producers can share one 32-bit consumer.

---
 rtl/rr_mux_pkg.sv | 41 ++++
 rtl/rr_mux_reg_if.sv | 30 +++
 rtl/rr_mux_reg_arbiter.sv | 32 +++
 rtl/rr_mux_reg.sv | 97 +++++++++
 tb/tb_rr_mux_reg.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the round-robin registered selector.
// Optional build macro: RR_MUX_FORCE_SEL_EN (forced channel selection).
package rr_mux_pkg;

  localparam int unsigned RR_WIDTH  = 32;
  localparam int unsigned RR_NUM_CH = 8;
  // Helpers operate on the largest legal channel count; callers pad/truncate.
  localparam int unsigned RR_MAX_CH = 16;
  localparam int unsigned RR_IDX_W  = 4;

  typedef logic [RR_IDX_W-1:0] rr_idx_t;

  typedef struct packed {
    logic    found;
    rr_idx_t idx;
  } rr_pick_t;

  // idx + 1, wrapping to 0 at n (n need not be a power of two).
  function automatic rr_idx_t rr_wrap_inc(input rr_idx_t idx, input int unsigned n);
    if (32'(idx) + 1 >= n) return '0;
    return idx + rr_idx_t'(1);
  endfunction

  // First set bit of req scanning ptr, ptr+1, ..., n-1, 0, ..., ptr-1.
  function automatic rr_pick_t rr_first(input logic [RR_MAX_CH-1:0] req,
                                        input rr_idx_t ptr, input int unsigned n);
    rr_pick_t    r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < RR_MAX_CH; k++) begin
      j = 32'(ptr) + k;
      if (j >= n) j = j - n;
      if (k < n && !r.found && req[rr_idx_t'(j)]) begin
        r.found = 1'b1;
        r.idx   = rr_idx_t'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_mux_reg_if.sv
// Handshake bundle between NUM_CH producers, the selector and one consumer.
// Optional build macro: RR_MUX_FORCE_SEL_EN (force ports live on the top, not here).
interface rr_mux_reg_if
  import rr_mux_pkg::*;
#(
  parameter int unsigned WIDTH  = RR_WIDTH,
  parameter int unsigned NUM_CH = RR_NUM_CH
) ();
  localparam int unsigned SEL_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_ready;

  // Selector side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/rr_mux_reg_arbiter.sv
// Rotating-priority arbiter: one-hot grant plus encoded index.
// Optional build macro: RR_MUX_FORCE_SEL_EN (handled upstream via req masking).
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter  int unsigned NUM_CH = RR_NUM_CH,
  localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  gidx,
  output logic              found
);

  rr_pick_t pick;

  // Search from ptr for the first requester
  always_comb begin
    pick = rr_first(RR_MAX_CH'(req), RR_IDX_W'(ptr), NUM_CH);
  end

  assign found = pick.found;
  assign gidx  = SEL_W'(pick.idx);

  // Grant is gated by en so a stalled output never strobes a producer.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_gnt
    assign grant[i] = en & pick.found & (pick.idx == RR_IDX_W'(i));
  end

endmodule

// File: rtl/rr_mux_reg.sv
// N:1 round-robin selector with a registered output beat.
// Optional build macro: RR_MUX_FORCE_SEL_EN adds force_en/force_sel to
// restrict eligibility to a single channel.
module rr_mux_reg
  import rr_mux_pkg::*;
#(
  parameter  int unsigned WIDTH  = RR_WIDTH,
  parameter  int unsigned NUM_CH = RR_NUM_CH,
  localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef RR_MUX_FORCE_SEL_EN
  input  logic             force_en,
  input  logic [SEL_W-1:0] force_sel,
`endif
  rr_mux_reg_if.slave      bus
);

  logic [NUM_CH-1:0][WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0]            elig;
  logic [NUM_CH-1:0]            grant;
  logic [SEL_W-1:0]             gidx;
  logic                         found;
  logic                         can_load;
  logic                         load;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_ch_q,    out_ch_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  assign ch_data = bus.in_data;

  // Eligible requesters (optionally narrowed to one forced channel)
  always_comb begin
    elig = bus.in_valid;
`ifdef RR_MUX_FORCE_SEL_EN
    if (force_en) begin
      // An out-of-range force_sel matches no channel, so nothing is eligible.
      for (int i = 0; i < NUM_CH; i++)
        elig[i] = bus.in_valid[i] & (force_sel == SEL_W'(i));
    end
`endif
  end

  // Output register can take a beat when empty or being drained this cycle.
  assign can_load = !out_valid_q || bus.out_ready;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req   (elig),
    .ptr   (ptr_q),
    .en    (can_load),
    .grant (grant),
    .gidx  (gidx),
    .found (found)
  );

  assign load        = can_load & found;
  assign bus.in_ready = grant;

  // Next-state: load replaces, drain clears valid, stall holds everything
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[gidx];
      out_ch_d    = gidx;
      ptr_d       = SEL_W'(rr_wrap_inc(RR_IDX_W'(gidx), NUM_CH));
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers, async clear discards any held beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Bench for rr_mux_reg: an 8-channel and a 5-channel instance share stimulus
// and are each compared against a queue-free behavioural model.
// Optional build macro: RR_MUX_FORCE_SEL_EN enables the force checks.
`timescale 1ns/1ps
module tb_rr_mux_reg;
  import rr_mux_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]       vin;
  logic [7:0][31:0] din;
  logic             ordy;
`ifdef RR_MUX_FORCE_SEL_EN
  logic             fen;
  logic [2:0]       fsel;
`endif

  rr_mux_reg_if #(.WIDTH(32), .NUM_CH(8)) if8 ();
  rr_mux_reg_if #(.WIDTH(32), .NUM_CH(5)) if5 ();

  assign if8.in_valid  = vin;
  assign if8.in_data   = din;
  assign if8.out_ready = ordy;
  assign if5.in_valid  = vin[4:0];
  assign if5.in_data   = din[4:0];
  assign if5.out_ready = ordy;

  rr_mux_reg #(.WIDTH(32), .NUM_CH(8)) dut8 (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef RR_MUX_FORCE_SEL_EN
    .force_en  (fen),
    .force_sel (fsel),
`endif
    .bus       (if8)
  );

  rr_mux_reg #(.WIDTH(32), .NUM_CH(5)) dut5 (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef RR_MUX_FORCE_SEL_EN
    .force_en  (fen),
    .force_sel (fsel),
`endif
    .bus       (if5)
  );

  // Reference model state, index 0 = 8-channel, 1 = 5-channel
  int          nch [2] = '{8, 5};
  bit          m_vld [2];
  logic [31:0] m_dat [2];
  int          m_ch  [2];
  int          m_ptr [2];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] act_rdy(input int d);
    return (d == 0) ? 32'(if8.in_ready) : 32'(if5.in_ready);
  endfunction
  function automatic logic [31:0] act_vld(input int d);
    return (d == 0) ? 32'(if8.out_valid) : 32'(if5.out_valid);
  endfunction
  function automatic logic [31:0] act_dat(input int d);
    return (d == 0) ? if8.out_data : if5.out_data;
  endfunction
  function automatic logic [31:0] act_ch(input int d);
    return (d == 0) ? 32'(if8.out_ch) : 32'(if5.out_ch);
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_vld[d] = 1'b0; m_dat[d] = '0; m_ch[d] = 0; m_ptr[d] = 0;
    end
  endtask

  // Which channel the spec says is accepted this cycle, or -1
  function automatic int m_pick(input int d);
    bit [7:0] e;
    e = vin;
`ifdef RR_MUX_FORCE_SEL_EN
    if (fen) begin
      e = '0;
      if (int'(fsel) < nch[d]) e[fsel] = vin[fsel];
    end
`endif
    if (m_vld[d] && !ordy) return -1;
    for (int k = 0; k < nch[d]; k++) begin
      int j;
      j = (m_ptr[d] + k) % nch[d];
      if (e[j]) return j;
    end
    return -1;
  endfunction

  // One clock: check in_ready, advance model at the edge, check outputs
  task automatic cyc();
    int g [2];
    #1;
    for (int d = 0; d < 2; d++) begin
      g[d] = m_pick(d);
      chk($sformatf("in_ready%0d", nch[d]), act_rdy(d), (g[d] < 0) ? 32'd0 : (32'd1 << g[d]));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (g[d] >= 0) begin
        m_vld[d] = 1'b1;
        m_dat[d] = din[g[d]];
        m_ch[d]  = g[d];
        m_ptr[d] = (g[d] + 1) % nch[d];
      end else if (ordy) begin
        m_vld[d] = 1'b0;
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("out_valid%0d", nch[d]), act_vld(d), 32'(m_vld[d]));
      chk($sformatf("out_data%0d",  nch[d]), act_dat(d), m_dat[d]);
      chk($sformatf("out_ch%0d",    nch[d]), act_ch(d),  32'(m_ch[d]));
    end
  endtask

  task automatic rst_vals(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_vld%0d", tag, nch[d]), act_vld(d), 32'd0);
      chk($sformatf("%s_dat%0d", tag, nch[d]), act_dat(d), 32'd0);
      chk($sformatf("%s_ch%0d",  tag, nch[d]), act_ch(d),  32'd0);
    end
  endtask

  initial begin
    vin = '0; din = '0; ordy = 1'b0;
`ifdef RR_MUX_FORCE_SEL_EN
    fen = 1'b0; fsel = '0;
`endif
    m_reset();
    @(negedge clk); @(negedge clk);
    rst_vals("reset");
    reset_n = 1'b1;

    // Round robin across all channels
    for (int i = 0; i < 8; i++) din[i] = 32'hC0DE_0000 + 32'(i);
    vin = 8'hFF; ordy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cyc();
      chk("rr_ch",  act_ch(0),  32'(k % 8));
      chk("rr_dat", act_dat(0), 32'hC0DE_0000 + 32'(k % 8));
      chk("rr_vld", act_vld(0), 32'd1);
    end

    // Backpressure: hold a beat from channel 3
    vin = 8'h00; cyc();
    vin = 8'h08; din[3] = 32'hDEADBEEF; cyc();
    ordy = 1'b0; vin = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_dat", act_dat(0), 32'hDEADBEEF);
      chk("bp_ch",  act_ch(0),  32'd3);
      chk("bp_rdy", act_rdy(0), 32'd0);
    end
    ordy = 1'b1; cyc();
    chk("bp_next_ch",  act_ch(0),  32'd4);
    chk("bp_next_vld", act_vld(0), 32'd1);

    // Sparse requests and wrap on the 5-channel instance
    vin = 8'h00; cyc();
    vin = 8'h08; cyc();            // ptr of the 5-channel unit becomes 4
    vin = 8'h00; cyc();
    vin = 8'h02; cyc();
    chk("wrap_ch1", act_ch(1), 32'd1);
    vin = 8'h11; cyc();
    chk("wrap_ch4", act_ch(1), 32'd4);
    cyc();
    chk("wrap_ch0", act_ch(1), 32'd0);

    // Drain then idle: pointer must not move
    vin = 8'h00; cyc();
    chk("drain_vld8", act_vld(0), 32'd0);
    chk("drain_vld5", act_vld(1), 32'd0);
    repeat (3) cyc();
    vin = 8'hFF; cyc();
    chk("idle_ptr8", act_ch(0), 32'd1);
    chk("idle_ptr5", act_ch(1), 32'd1);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      vin  = 8'($urandom);
      for (int i = 0; i < 8; i++) din[i] = $urandom;
      ordy = ($urandom_range(0, 3) != 0);
      cyc();
    end

`ifdef RR_MUX_FORCE_SEL_EN
    // Forced channel 6: in range for 8 channels, out of range for 5
    fen = 1'b1; fsel = 3'd6; vin = 8'hFF; ordy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("force_ch8",  act_ch(0),  32'd6);
      chk("force_vld8", act_vld(0), 32'd1);
      chk("force_vld5", act_vld(1), 32'd0);
    end
    fen = 1'b0;
`endif

    // Asynchronous reset in the middle of a transfer
    vin = 8'hFF; ordy = 1'b1; cyc();
    chk("pre_rst_vld", act_vld(0), 32'd1);
    #3 reset_n = 1'b0;
    #1 rst_vals("async_rst");
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    chk("post_rst_ch8", act_ch(0), 32'd0);
    chk("post_rst_ch5", act_ch(1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
